// File: rtl/fp_pkg.sv
// Shared definitions for the sequential floating-point add/subtract unit:
// FSM state encoding, flag bit positions and canonical special-value patterns.
package fp_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SPECIAL = 3'd1,
        S_ALIGN   = 3'd2,
        S_ADD     = 3'd3,
        S_NORM    = 3'd4,
        S_ROUND   = 3'd5,
        S_DONE    = 3'd6
    } state_e;

    // Bit positions inside the 4-bit flags word {invalid, overflow, underflow, inexact}
    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    // Widest format the pattern helpers can describe; callers size-cast the result
    localparam int FP_MAX_W = 128;

    // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set
    function automatic logic [FP_MAX_W-1:0] canon_qnan(input int exp_w, input int man_w);
        logic [FP_MAX_W-1:0] one;
        one = 1;
        return (((one << exp_w) - one) << man_w) | (one << (man_w - 1));
    endfunction

    // Positive infinity: sign 0, exponent all ones, fraction zero
    function automatic logic [FP_MAX_W-1:0] pos_inf(input int exp_w, input int man_w);
        logic [FP_MAX_W-1:0] one;
        one = 1;
        return ((one << exp_w) - one) << man_w;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
    parameter int WIDTH = 56,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] count
);

    // Scan upward so the highest set bit is the last one to write the count
    always_comb begin
        count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) begin
                count = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 adder/subtractor, one operation in flight.
// Handshake: an operand set is taken on a rising edge where in_valid && in_ready;
// a result is consumed on a rising edge where out_valid && out_ready, and
// SUM/flags hold steady for as long as out_valid is high and out_ready is low.
module fp_addsub_seq
    import fp_pkg::*;
#(
    parameter int EXP_W = 11,
    parameter int MAN_W = 52,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         Clock,
    input  logic         Reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         op,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] SUM,
    output logic [3:0]   flags,
    output state_e       dbg_state
);

    localparam int SIG_W = MAN_W + 1;          // hidden bit + fraction
    localparam int EXT_W = MAN_W + 4;          // significand + guard, round, sticky
    localparam int SUM_W = MAN_W + 5;          // extended significand + carry
    localparam int E_W   = EXP_W + 1;          // exponent with headroom for +2
    localparam int LZ_W  = $clog2(EXT_W + 1);

    localparam logic [W-1:0]   QNAN     = W'(canon_qnan(EXP_W, MAN_W));
    localparam logic [W-2:0]   INF_MAG  = (W-1)'(pos_inf(EXP_W, MAN_W));
    localparam logic [E_W-1:0] EXP_ONES = {1'b0, {EXP_W{1'b1}}};

    state_e         state;
    logic [W-1:0]   a_r, b_r;
    logic           al_sign, al_sub;
    logic [E_W-1:0] al_exp;
    logic [EXT_W-1:0] al_big, al_small;
    logic           ad_sign;
    logic [E_W-1:0] ad_exp;
    logic [SUM_W-1:0] ad_sum;
    logic           nm_sign;
    logic [E_W-1:0] nm_exp;
    logic [EXT_W-1:0] nm_sig;
    logic [W-1:0]   sum_r;
    logic [3:0]     flags_r;
    logic           out_valid_r, in_ready_r;

    // Operand field decode (b_r already carries the op-adjusted sign)
    logic             a_sign, b_sign;
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_frac, b_frac;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [SIG_W-1:0] a_sig, b_sig;
    logic [E_W-1:0]   a_eexp, b_eexp;

    assign a_sign = a_r[W-1];
    assign b_sign = b_r[W-1];
    assign a_exp  = a_r[W-2:MAN_W];
    assign b_exp  = b_r[W-2:MAN_W];
    assign a_frac = a_r[MAN_W-1:0];
    assign b_frac = b_r[MAN_W-1:0];
    assign a_nan  = (&a_exp) && (a_frac != '0);
    assign b_nan  = (&b_exp) && (b_frac != '0);
    assign a_inf  = (&a_exp) && (a_frac == '0);
    assign b_inf  = (&b_exp) && (b_frac == '0);
    assign a_zero = (a_exp == '0) && (a_frac == '0);
    assign b_zero = (b_exp == '0) && (b_frac == '0);
    // Subnormals: hidden bit 0, effective exponent 1
    assign a_sig  = {a_exp != '0, a_frac};
    assign b_sig  = {b_exp != '0, b_frac};
    assign a_eexp = (a_exp == '0) ? E_W'(1) : {1'b0, a_exp};
    assign b_eexp = (b_exp == '0) ? E_W'(1) : {1'b0, b_exp};

    // Special-operand screening: NaN / Inf / both-zero short-cut results
    logic         sp_hit;
    logic [W-1:0] sp_sum;
    logic [3:0]   sp_flags;

    always_comb begin
        sp_hit   = 1'b1;
        sp_sum   = '0;
        sp_flags = '0;
        if (a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign))) begin
            sp_sum                 = QNAN;
            sp_flags[FLAG_INVALID] = 1'b1;
        end else if (a_inf) begin
            sp_sum = {a_sign, INF_MAG};
        end else if (b_inf) begin
            sp_sum = {b_sign, INF_MAG};
        end else if (a_zero && b_zero) begin
            sp_sum = {a_sign & b_sign, {(W-1){1'b0}}};
        end else begin
            sp_hit = 1'b0;
        end
    end

    // Alignment: larger magnitude first, smaller shifted right with sticky collapse
    logic             a_is_big, big_sign;
    logic [E_W-1:0]   big_eexp, small_eexp, exp_diff;
    logic [SIG_W-1:0] big_sig, small_sig;
    logic [EXT_W-1:0] small_base, small_shift;

    always_comb begin
        a_is_big   = (a_r[W-2:0] >= b_r[W-2:0]);
        big_sign   = a_is_big ? a_sign : b_sign;
        big_eexp   = a_is_big ? a_eexp : b_eexp;
        small_eexp = a_is_big ? b_eexp : a_eexp;
        big_sig    = a_is_big ? a_sig  : b_sig;
        small_sig  = a_is_big ? b_sig  : a_sig;
        exp_diff   = big_eexp - small_eexp;
        small_base = {small_sig, 3'b000};
        if (exp_diff >= E_W'(EXT_W - 1)) begin
            small_shift = {{(EXT_W-1){1'b0}}, |small_sig};
        end else begin
            small_shift = small_base >> exp_diff;
            if ((small_shift << exp_diff) != small_base) begin
                small_shift[0] = 1'b1;
            end
        end
    end

    // Significand add or magnitude subtract
    logic [SUM_W-1:0] add_sum;

    always_comb begin
        if (al_sub) add_sum = {1'b0, al_big} - {1'b0, al_small};
        else        add_sum = {1'b0, al_big} + {1'b0, al_small};
    end

    // Normalisation: carry -> shift right; else left by LZC, exponent floored at 1
    logic [LZ_W-1:0]  lz_count;
    logic [E_W-1:0]   lz_ext, max_shift, shamt, norm_exp;
    logic [EXT_W-1:0] norm_sig;

    fp_lzc #(.WIDTH(EXT_W)) u_lzc (
        .value (ad_sum[EXT_W-1:0]),
        .count (lz_count)
    );

    always_comb begin
        lz_ext    = E_W'(lz_count);
        max_shift = ad_exp - E_W'(1);
        shamt     = (lz_ext > max_shift) ? max_shift : lz_ext;
        if (ad_sum[SUM_W-1]) begin
            norm_sig = {ad_sum[SUM_W-1:2], ad_sum[1] | ad_sum[0]};
            norm_exp = ad_exp + E_W'(1);
        end else begin
            norm_sig = ad_sum[EXT_W-1:0] << shamt;
            norm_exp = ad_exp - shamt;
        end
    end

    // Round to nearest even, then overflow / flush-to-zero packing
    logic [SIG_W-1:0] mant, rmant;
    logic [SIG_W:0]   rsum;
    logic [E_W-1:0]   rexp;
    logic             g_bit, r_bit, s_bit, round_up, inexact;
    logic [W-1:0]     rnd_sum;
    logic [3:0]       rnd_flags;

    always_comb begin
        mant     = nm_sig[EXT_W-1:3];
        g_bit    = nm_sig[2];
        r_bit    = nm_sig[1];
        s_bit    = nm_sig[0];
        inexact  = g_bit | r_bit | s_bit;
        round_up = g_bit & (r_bit | s_bit | mant[0]);
        rsum     = {1'b0, mant} + {{SIG_W{1'b0}}, round_up};
        if (rsum[SIG_W]) begin
            rmant = rsum[SIG_W:1];
            rexp  = nm_exp + E_W'(1);
        end else begin
            rmant = rsum[SIG_W-1:0];
            rexp  = nm_exp;
        end
        rnd_flags = '0;
        if (rexp >= EXP_ONES) begin
            rnd_sum                  = {nm_sign, INF_MAG};
            rnd_flags[FLAG_OVERFLOW] = 1'b1;
            rnd_flags[FLAG_INEXACT]  = 1'b1;
        end else if (!rmant[SIG_W-1]) begin
            rnd_sum = {nm_sign, {(W-1){1'b0}}};
            if ((rmant != '0) || inexact) begin
                rnd_flags[FLAG_UNDERFLOW] = 1'b1;
                rnd_flags[FLAG_INEXACT]   = 1'b1;
            end
        end else begin
            rnd_sum                 = {nm_sign, rexp[EXP_W-1:0], rmant[MAN_W-1:0]};
            rnd_flags[FLAG_INEXACT] = inexact;
        end
    end

    // Control FSM and all pipeline registers; every state advances one step per edge
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state       <= S_IDLE;
            a_r         <= '0;
            b_r         <= '0;
            al_sign     <= 1'b0;
            al_sub      <= 1'b0;
            al_exp      <= '0;
            al_big      <= '0;
            al_small    <= '0;
            ad_sign     <= 1'b0;
            ad_exp      <= '0;
            ad_sum      <= '0;
            nm_sign     <= 1'b0;
            nm_exp      <= '0;
            nm_sig      <= '0;
            sum_r       <= '0;
            flags_r     <= '0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready_r) begin
                        a_r        <= A;
                        b_r        <= {B[W-1] ^ op, B[W-2:0]};
                        in_ready_r <= 1'b0;
                        state      <= S_SPECIAL;
                    end
                end
                S_SPECIAL: begin
                    if (sp_hit) begin
                        sum_r       <= sp_sum;
                        flags_r     <= sp_flags;
                        out_valid_r <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        state <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    al_sign  <= big_sign;
                    al_sub   <= a_sign ^ b_sign;
                    al_exp   <= big_eexp;
                    al_big   <= {big_sig, 3'b000};
                    al_small <= small_shift;
                    state    <= S_ADD;
                end
                S_ADD: begin
                    ad_sum  <= add_sum;
                    ad_exp  <= al_exp;
                    // Exact cancellation always yields +0
                    ad_sign <= (add_sum == '0) ? 1'b0 : al_sign;
                    state   <= S_NORM;
                end
                S_NORM: begin
                    nm_sig  <= norm_sig;
                    nm_exp  <= norm_exp;
                    nm_sign <= ad_sign;
                    state   <= S_ROUND;
                end
                S_ROUND: begin
                    sum_r       <= rnd_sum;
                    flags_r     <= rnd_flags;
                    out_valid_r <= 1'b1;
                    state       <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign SUM       = sum_r;
    assign flags     = flags_r;
    assign dbg_state = state;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed-vector bench for fp_addsub_seq: a double-precision instance with a
// scoreboard (value, flags, latency) and a single-precision instance with its own.
module tb_fp_addsub_seq;
    import fp_pkg::*;

    localparam int W  = 64;
    localparam int WS = 32;

    // ---------------- clock / reset ----------------
    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- double-precision DUT ----------------
    logic         Reset_n = 1'b0;
    logic         in_valid = 1'b0, op = 1'b0, out_ready = 1'b1;
    logic [W-1:0] A = '0, B = '0;
    logic         in_ready, out_valid;
    logic [W-1:0] SUM;
    logic [3:0]   flags;
    state_e       dbg_state;

    fp_addsub_seq u_dut (
        .Clock(Clock), .Reset_n(Reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .SUM(SUM), .flags(flags), .dbg_state(dbg_state)
    );

    // ---------------- single-precision DUT ----------------
    logic          rst1_n = 1'b0;
    logic          in_valid1 = 1'b0, op1 = 1'b0;
    logic [WS-1:0] a1 = '0, b1 = '0;
    logic          in_ready1, out_valid1;
    logic [WS-1:0] sum1;
    logic [3:0]    flags1;
    state_e        dbg_state1;
    bit            sp_done = 1'b0;

    fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) u_dut_sp (
        .Clock(Clock), .Reset_n(rst1_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .op(op1), .A(a1), .B(b1), .out_valid(out_valid1), .out_ready(1'b1),
        .SUM(sum1), .flags(flags1), .dbg_state(dbg_state1)
    );

    // ---------------- scoreboards ----------------
    logic [W+3:0]  exp_q[$];
    int            id_q[$];
    int            lat_q[$];
    int            acc_q[$];
    logic [WS+3:0] sp_q[$];
    int            vid = 0;
    int            last_acc = 0;
    bit            ov_seen = 1'b0;

    task automatic check(input string name, input logic [W+3:0] got, input logic [W+3:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Monitor for the double-precision DUT: latency on rise, value on handshake
    always @(negedge Clock) begin
        if (out_valid && !ov_seen) begin
            ov_seen = 1'b1;
            if (lat_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_out_valid: SUM=%h with nothing outstanding", SUM);
            end else begin
                int lat, acc;
                lat = lat_q.pop_front();
                acc = acc_q.pop_front();
                check($sformatf("vec%0d latency", id_q[0]), 68'(cyc - acc), 68'(lat));
            end
        end
        if (out_valid && out_ready) begin
            ov_seen = 1'b0;
            if (exp_q.size() != 0) begin
                logic [W+3:0] e;
                int id;
                e  = exp_q.pop_front();
                id = id_q.pop_front();
                check($sformatf("vec%0d sum_flags", id), {SUM, flags}, e);
            end
        end
    end

    // Monitor for the single-precision DUT
    always @(negedge Clock) begin
        if (out_valid1) begin
            if (sp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sp_unexpected: sum1=%h with nothing outstanding", sum1);
            end else begin
                logic [WS+3:0] e;
                e = sp_q.pop_front();
                check("sp sum_flags", 68'({sum1, flags1}), 68'(e));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic o,
                        input logic [W-1:0] es, input logic [3:0] ef, input int lat, input bit chk);
        int guard;
        guard = 0;
        A = a; B = b; op = o; in_valid = 1'b1;
        while (!in_ready && guard < 60) begin
            @(posedge Clock); #1;
            guard++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: in_ready=%b, expected 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge Clock); #1;
        in_valid = 1'b0;
        last_acc = cyc;
        if (chk) begin
            exp_q.push_back({es, ef});
            id_q.push_back(vid);
            lat_q.push_back(lat);
            acc_q.push_back(cyc);
        end
        vid++;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (!in_ready && guard < 60) begin
            @(posedge Clock); #1;
            guard++;
        end
    endtask

    task automatic send_sp(input logic [WS-1:0] a, input logic [WS-1:0] b, input logic o,
                           input logic [WS-1:0] es, input logic [3:0] ef);
        int guard;
        guard = 0;
        a1 = a; b1 = b; op1 = o; in_valid1 = 1'b1;
        while (!in_ready1 && guard < 60) begin
            @(posedge Clock); #1;
            guard++;
        end
        if (!in_ready1) begin
            n_vec++;
            n_err++;
            $display("FAIL sp_accept_timeout: in_ready1=%b, expected 1", in_ready1);
            in_valid1 = 1'b0;
            return;
        end
        sp_q.push_back({es, ef});
        @(posedge Clock); #1;
        in_valid1 = 1'b0;
    endtask

    // ---------------- single-precision stimulus ----------------
    initial begin
        repeat (3) @(posedge Clock);
        #1 rst1_n = 1'b1;
        send_sp(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
        send_sp(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);
        send_sp(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
        send_sp(32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 4'b0000);
        sp_done = 1'b1;
    end

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main double-precision sequence ----------------
    initial begin
        int t0, guard;
        bit ov_rose;

        // Reset state
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check("reset SUM", 68'(SUM), 68'(0));
        check("reset flags", 68'(flags), 68'(0));
        check("reset out_valid", 68'(out_valid), 68'(0));
        @(posedge Clock); #1;
        Reset_n = 1'b1;
        check("in_ready after reset", 68'(in_ready), 68'(1));

        // Back-to-back normal-path pair: 1+2, 1-1
        send(64'h3FF0000000000000, 64'h4000000000000000, 1'b0, 64'h4008000000000000, 4'b0000, 5, 1'b1);
        t0 = last_acc;
        send(64'h3FF0000000000000, 64'h3FF0000000000000, 1'b1, 64'h0000000000000000, 4'b0000, 5, 1'b1);
        check("throughput accept spacing", 68'(last_acc - t0), 68'(7));

        // Specials
        send(64'h7FF0000000000000, 64'hFFF0000000000000, 1'b0, 64'h7FF8000000000000, 4'b1000, 1, 1'b1);
        send(64'h7FF0000000000001, 64'h3FF0000000000000, 1'b0, 64'h7FF8000000000000, 4'b1000, 1, 1'b1);
        send(64'h7FF0000000000000, 64'h3FF0000000000000, 1'b1, 64'h7FF0000000000000, 4'b0000, 1, 1'b1);
        send(64'h8000000000000000, 64'h8000000000000000, 1'b0, 64'h8000000000000000, 4'b0000, 1, 1'b1);
        send(64'h0000000000000000, 64'h0000000000000000, 1'b1, 64'h0000000000000000, 4'b0000, 1, 1'b1);

        // Overflow, rounding ties, subtraction, subnormals, far alignment
        send(64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 1'b0, 64'h7FF0000000000000, 4'b0101, 5, 1'b1);
        send(64'h3FF0000000000000, 64'h3CA0000000000000, 1'b0, 64'h3FF0000000000000, 4'b0001, 5, 1'b1);
        send(64'h3FF0000000000001, 64'h3CA0000000000000, 1'b0, 64'h3FF0000000000002, 4'b0001, 5, 1'b1);
        send(64'h4000000000000000, 64'h4008000000000000, 1'b1, 64'hBFF0000000000000, 4'b0000, 5, 1'b1);
        send(64'h0010000000000001, 64'h0010000000000000, 1'b1, 64'h0000000000000000, 4'b0011, 5, 1'b1);
        send(64'h0000000000000001, 64'h0010000000000000, 1'b0, 64'h0010000000000001, 4'b0000, 5, 1'b1);
        send(64'h3FF0000000000000, 64'h0000000000000001, 1'b1, 64'h3FF0000000000000, 4'b0001, 5, 1'b1);
        send(64'h3FF8000000000000, 64'h3FF8000000000000, 1'b0, 64'h4008000000000000, 4'b0000, 5, 1'b1);

        // Back-pressure: result held five cycles, then a single out_ready pulse
        wait_idle();
        out_ready = 1'b0;
        send(64'h3FF0000000000000, 64'h4000000000000000, 1'b0, 64'h4008000000000000, 4'b0000, 5, 1'b1);
        guard = 0;
        while (!out_valid && guard < 20) begin
            @(posedge Clock); #1;
            guard++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            check($sformatf("hold%0d SUM", i), 68'(SUM), 68'(64'h4008000000000000));
            check($sformatf("hold%0d in_ready", i), 68'(in_ready), 68'(0));
        end
        @(posedge Clock); #1;
        out_ready = 1'b1;
        @(posedge Clock); #1;
        out_ready = 1'b0;
        @(negedge Clock);
        check("after pulse in_ready", 68'(in_ready), 68'(1));
        check("after pulse out_valid", 68'(out_valid), 68'(0));
        out_ready = 1'b1;

        // Abort in ALIGN with a one-cycle reset
        wait_idle();
        send(64'h3FF0000000000000, 64'h4000000000000000, 1'b0, '0, 4'b0000, 5, 1'b0);
        @(posedge Clock); #1;
        check("abort state is ALIGN", 68'(dbg_state), 68'(S_ALIGN));
        Reset_n = 1'b0;
        @(posedge Clock); #1;
        Reset_n = 1'b1;
        ov_rose = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            if (out_valid) ov_rose = 1'b1;
        end
        check("abort out_valid never rose", 68'(ov_rose), 68'(0));
        check("abort in_ready", 68'(in_ready), 68'(1));

        // Recovery after abort
        send(64'h3FF0000000000000, 64'h4000000000000000, 1'b0, 64'h4008000000000000, 4'b0000, 5, 1'b1);

        // Drain both scoreboards
        guard = 0;
        while ((exp_q.size() != 0 || sp_q.size() != 0 || !sp_done) && guard < 300) begin
            @(posedge Clock); #1;
            guard++;
        end
        if (exp_q.size() != 0 || sp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d dp and %0d sp results outstanding, expected 0",
                     exp_q.size(), sp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
